debug_unit: RTL
===============

# debug_unit

Host-side controller for the pipeline's debug port. Consumes command bytes from the UART receiver, loads programs into instruction memory, and runs the pipeline continuously or single-steps it. On halt or step completion, it reads back the PC, the register file and data memory, and serialises them to the UART transmitter. It sits between the UART RX/TX pair and the pipeline top.

## Interface
- `NB_DATA`, 32, pipeline word width
- `NB_REG`, 5, register address width
- `N_BITS`, 8, UART byte width
- `N_REGISTER`, 32, registers dumped
- `N_DM_WORDS`, 32, data-memory words dumped
- `ADDRWIDTH`, from `parameters.vh`, IM/DM address width
- `i_clock` in 1: single clock
- `i_reset` in 1: reset, asynchronous, active-low
- `i_rx_data` in N_BITS: received byte
- `i_rx_valid` in 1: one-cycle pulse, byte valid
- `o_tx_data` out N_BITS: byte to send
- `o_tx_start` out 1: one-cycle pulse, start transmit
- `i_tx_done` in 1: one-cycle pulse, byte sent
- `o_im_data` out NB_DATA: instruction word
- `o_im_addr` out ADDRWIDTH: instruction byte address
- `o_im_enable_write` out 1: IM write strobe
- `o_debug_unit` out 1: high while loading
- `o_en_read` out 1: IM read enable, high outside load
- `o_enable_pipe` out 1: pipeline advance
- `o_br_addr` out NB_REG: register read address
- `o_br_enable` out 1: register debug read
- `o_dm_addr` out ADDRWIDTH: memory read address
- `o_dm_enable`, `o_dm_enable_addr`, `o_dm_enable_read`, `o_enable_mem` out 1 each: memory debug read controls
- `i_pc` in ADDRWIDTH: current PC
- `i_data_reg` in NB_DATA: register readback
- `i_data_mem` in NB_DATA: memory readback
- `i_halt` in 1: pipeline halted
- `o_busy` out 1: not in IDLE

## Operation
- **Commands** (first byte in IDLE): 0x01 LOAD, 0x02 RUN, 0x03 STEP. Any other byte is ignored and the block stays in IDLE.
- **LOAD**
  - Next byte is N, the instruction count.
  - Then 4N bytes, MSB first.
  - Each completed word is written with a one-cycle `o_im_enable_write` at `o_im_addr`. The address starts at 0 and increments by 4.
  - After the last write, return to IDLE.
  - N=0: return to IDLE with no write.
  - `o_debug_unit` is high from command until exit.
- **RUN**: hold `o_enable_pipe` high until `i_halt` is sampled high. Then deassert and enter DUMP.
- **STEP**: assert `o_enable_pipe` for exactly one cycle, then enter DUMP.
- **DUMP**, sent in this order:
  - PC as 4 bytes.
  - Registers 0..N_REGISTER-1, 4 bytes each.
  - Memory words 0..N_DM_WORDS-1, 4 bytes each. Memory addresses are byte addresses, stepping by 4.
  - Every word is MSB first.
- **Dump flow per word**: present the address with its enable high in SETUP. Latch the readback in CAPTURE, one cycle later. Then SEND 4 bytes.
- **Per byte**: pulse `o_tx_start` with `o_tx_data` valid, hold the data, wait for `i_tx_done`.
- **States**: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_SETUP, DUMP_CAPTURE, DUMP_SEND, DUMP_WAIT. After the final byte, return to IDLE.
- **Ignored inputs**:
  - `i_rx_valid` in RUN, STEP or DUMP_* is dropped.
  - `i_halt` outside RUN is ignored.
  - `i_tx_done` outside DUMP_WAIT is ignored.
- **STEP while halted**: the step still pulses and the dump is still produced.
- **Counters**: the byte counter is 2 bits and wraps 3→0 per word. Word counters are sized for N_REGISTER + N_DM_WORDS + 1.

## Timing
- **Reset**: while `i_reset` is low, the state is IDLE and every output is 0, except `o_en_read`=1. Asserting reset mid-operation aborts immediately and the partially loaded word is discarded.
- **IM write**: `o_im_enable_write` pulses the cycle after the 4th byte's `i_rx_valid`.
- **RUN stop**: `o_enable_pipe` drops the cycle after `i_halt` is sampled high.
- **STEP**: the `o_enable_pipe` pulse is one cycle wide, and DUMP_SETUP follows two cycles later so the halt/PC can settle.
- **Transmit**: first `o_tx_start` occurs 3 cycles after entering DUMP. Each following byte starts the cycle after `i_tx_done`.
- **Outputs**: all outputs are registered.

## Configuration
- `DEBUG_UNIT_MEM_DUMP_EN`
  - Defined: the memory section is dumped, 4+4·N_REGISTER+4·N_DM_WORDS bytes in total (260 with defaults).
  - Undefined: memory-read outputs are tied to 0 and the dump is PC plus registers only (132 bytes).

## Structure
- **`parameters.vh`** gains the command codes (`CMD_LOAD`, `CMD_RUN`, `CMD_STEP`) and the state encodings.
- **`debug_word_serializer`** is one sub-module. It loads a 32-bit word, emits 4 bytes MSB first over the tx_start/tx_done handshake, and signals word done.

## Test plan
- LOAD 0x01,0x02, then bytes 0x20,0x01,0x00,0x05, 0x00,0x00,0x00,0x3F → writes 0x20010005@0 and 0x0000003F@4, then returns to IDLE.
- LOAD with N=0 → no `o_im_enable_write`, IDLE the next cycle.
- RUN 0x02 with `i_halt` raised after 10 cycles → `o_enable_pipe` high for 10 cycles, then 260 bytes. The first 4 bytes equal `i_pc` MSB first, and the TX bytes follow the `i_data_reg` values stubbed per `o_br_addr`.
- STEP 0x03 → exactly one `o_enable_pipe` cycle, then a full dump. Delaying `i_tx_done` by 100 cycles holds `o_tx_data` stable.
- Invalid byte 0x7E, and RX bytes injected during a dump → no state change and no corruption of the dump stream.
- Reset asserted mid-LOAD after 2 data bytes → outputs zero at once; after release, a fresh LOAD writes from address 0.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// Shared constants for the debug unit: host command codes, FSM state encoding
// and the default IM/DM address width.
package debug_unit_pkg;

    localparam int unsigned ADDRWIDTH_DEF = 32;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;

    typedef enum logic [3:0] {
        StIdle,
        StLoadCnt,
        StLoadByte,
        StLoadWrite,
        StRun,
        StStep,
        StDumpSetup,
        StDumpCapture,
        StDumpSend,
        StDumpWait
    } state_e;

endpackage

// File: rtl/debug_word_serializer.sv
// Splits a loaded word into bytes, MSB first, over the tx_start/tx_done handshake;
// o_word_done flags the tx_done of the last byte.
module debug_word_serializer #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned N_BITS  = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_start,
    input  logic               i_tx_done,
    output logic [N_BITS-1:0]  o_tx_data,
    output logic               o_tx_start,
    output logic               o_word_done
);

    logic [NB_DATA-1:0] word_q, word_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               tx_start_q, tx_start_d;
    logic [N_BITS-1:0]  tx_data_q, tx_data_d;

    always_comb begin
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        o_word_done = i_tx_done && (byte_cnt_q == 2'd3);
        if (i_load) begin
            word_d     = i_word;
            byte_cnt_d = 2'd0;
        end else if (i_start || (i_tx_done && (byte_cnt_q != 2'd3))) begin
            // Emit the top byte and shift the next one into place.
            tx_start_d = 1'b1;
            tx_data_d  = word_q[NB_DATA-1 -: N_BITS];
            word_d     = word_q << N_BITS;
            if (i_tx_done) byte_cnt_d = byte_cnt_q + 2'd1;
        end else if (o_word_done) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word_q     <= '0;
            byte_cnt_q <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;

endmodule

// File: rtl/debug_unit.sv
// Debug-port controller: UART commands load IM, run or step the pipeline, then dump
// PC, registers and (with DEBUG_UNIT_MEM_DUMP_EN defined) data memory over UART TX.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int unsigned NB_DATA    = 32,
    parameter int unsigned NB_REG     = 5,
    parameter int unsigned N_BITS     = 8,
    parameter int unsigned N_REGISTER = 32,
    parameter int unsigned N_DM_WORDS = 32,
    parameter int unsigned ADDRWIDTH  = ADDRWIDTH_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [N_BITS-1:0]    i_rx_data,
    input  logic                 i_rx_valid,
    output logic [N_BITS-1:0]    o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic [NB_DATA-1:0]   o_im_data,
    output logic [ADDRWIDTH-1:0] o_im_addr,
    output logic                 o_im_enable_write,
    output logic                 o_debug_unit,
    output logic                 o_en_read,
    output logic                 o_enable_pipe,
    output logic [NB_REG-1:0]    o_br_addr,
    output logic                 o_br_enable,
    output logic [ADDRWIDTH-1:0] o_dm_addr,
    output logic                 o_dm_enable,
    output logic                 o_dm_enable_addr,
    output logic                 o_dm_enable_read,
    output logic                 o_enable_mem,
    input  logic [ADDRWIDTH-1:0] i_pc,
    input  logic [NB_DATA-1:0]   i_data_reg,
    input  logic [NB_DATA-1:0]   i_data_mem,
    input  logic                 i_halt,
    output logic                 o_busy
);

    localparam int unsigned WCW = $clog2(N_REGISTER + N_DM_WORDS + 2);
    typedef logic [WCW-1:0] wcnt_t;
`ifdef DEBUG_UNIT_MEM_DUMP_EN
    localparam wcnt_t LAST_WORD = wcnt_t'(N_REGISTER + N_DM_WORDS);
`else
    localparam wcnt_t LAST_WORD = wcnt_t'(N_REGISTER);
`endif

    state_e               state_q, state_d;
    logic [N_BITS-1:0]    load_left_q, load_left_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0]   word_q, word_d;
    logic [ADDRWIDTH-1:0] im_addr_q, im_addr_d;
    logic                 settle_q, settle_d;
    wcnt_t                widx_q, widx_d;
    logic                 pipe_q, pipe_d, im_we_q, im_we_d, debug_q, debug_d;
    logic                 en_read_q, en_read_d, busy_q, busy_d;
    logic [NB_REG-1:0]    br_addr_q, br_addr_d;
    logic                 br_en_q, br_en_d, dump_en_d, is_reg_d;
    logic [NB_DATA-1:0]   ser_word;
    logic                 ser_done, word_done;

    always_comb begin
        state_d     = state_q;
        load_left_d = load_left_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        im_addr_d   = im_addr_q;
        settle_d    = settle_q;
        widx_d      = widx_q;
        case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    if (i_rx_data == N_BITS'(CMD_LOAD)) begin
                        state_d   = StLoadCnt;
                        im_addr_d = '0;
                    end else if (i_rx_data == N_BITS'(CMD_RUN)) begin
                        state_d = StRun;
                    end else if (i_rx_data == N_BITS'(CMD_STEP)) begin
                        state_d  = StStep;
                        settle_d = 1'b0;
                    end
                end
            end
            StLoadCnt: begin
                if (i_rx_valid) begin
                    load_left_d = i_rx_data;
                    byte_cnt_d  = 2'd0;
                    state_d     = (i_rx_data == '0) ? StIdle : StLoadByte;
                end
            end
            StLoadByte: begin
                if (i_rx_valid) begin
                    word_d     = {word_q[NB_DATA-N_BITS-1:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = StLoadWrite;
                end
            end
            StLoadWrite: begin
                im_addr_d   = im_addr_q + ADDRWIDTH'(4);
                load_left_d = load_left_q - N_BITS'(1);
                state_d     = (load_left_q == N_BITS'(1)) ? StIdle : StLoadByte;
            end
            StRun: begin
                if (i_halt) begin
                    state_d = StDumpSetup;
                    widx_d  = '0;
                end
            end
            StStep: begin
                // One extra cycle after the pulse lets halt/PC settle before the dump.
                if (settle_q) begin
                    state_d  = StDumpSetup;
                    widx_d   = '0;
                    settle_d = 1'b0;
                end else begin
                    settle_d = 1'b1;
                end
            end
            StDumpSetup:   state_d = StDumpCapture;
            StDumpCapture: state_d = StDumpSend;
            StDumpSend:    state_d = StDumpWait;
            StDumpWait: begin
                if (word_done) begin
                    if (widx_q == LAST_WORD) begin
                        state_d = StIdle;
                    end else begin
                        widx_d  = widx_q + wcnt_t'(1);
                        state_d = StDumpSetup;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of what the next state wants.
        pipe_d    = (state_d == StRun) || ((state_d == StStep) && (state_q != StStep));
        im_we_d   = (state_d == StLoadWrite);
        debug_d   = (state_d == StLoadCnt) || (state_d == StLoadByte) || (state_d == StLoadWrite);
        en_read_d = !debug_d;
        busy_d    = (state_d != StIdle);
        dump_en_d = (state_d == StDumpSetup) || (state_d == StDumpCapture);
        is_reg_d  = (widx_d != '0) && (widx_d <= wcnt_t'(N_REGISTER));
        br_en_d   = dump_en_d && is_reg_d;
        br_addr_d = br_addr_q;
        if ((state_d == StDumpSetup) && is_reg_d) br_addr_d = NB_REG'(widx_d - wcnt_t'(1));
    end

    always_comb begin
        if (widx_q == '0) begin
            ser_word = NB_DATA'(i_pc);
        end else if (widx_q <= wcnt_t'(N_REGISTER)) begin
            ser_word = i_data_reg;
        end else begin
            ser_word = i_data_mem;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= StIdle;
            load_left_q <= '0;
            byte_cnt_q  <= 2'd0;
            word_q      <= '0;
            im_addr_q   <= '0;
            settle_q    <= 1'b0;
            widx_q      <= '0;
            pipe_q      <= 1'b0;
            im_we_q     <= 1'b0;
            debug_q     <= 1'b0;
            en_read_q   <= 1'b1;
            busy_q      <= 1'b0;
            br_addr_q   <= '0;
            br_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_left_q <= load_left_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            im_addr_q   <= im_addr_d;
            settle_q    <= settle_d;
            widx_q      <= widx_d;
            pipe_q      <= pipe_d;
            im_we_q     <= im_we_d;
            debug_q     <= debug_d;
            en_read_q   <= en_read_d;
            busy_q      <= busy_d;
            br_addr_q   <= br_addr_d;
            br_en_q     <= br_en_d;
        end
    end

`ifdef DEBUG_UNIT_MEM_DUMP_EN
    localparam wcnt_t FIRST_MEM = wcnt_t'(N_REGISTER + 1);
    logic                 dm_en_q, dm_en_d;
    logic [ADDRWIDTH-1:0] dm_addr_q, dm_addr_d;

    always_comb begin
        dm_en_d   = dump_en_d && (widx_d >= FIRST_MEM);
        dm_addr_d = dm_addr_q;
        if ((state_d == StDumpSetup) && (widx_d >= FIRST_MEM)) begin
            dm_addr_d = ADDRWIDTH'(widx_d - FIRST_MEM) << 2;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dm_en_q   <= 1'b0;
            dm_addr_q <= '0;
        end else begin
            dm_en_q   <= dm_en_d;
            dm_addr_q <= dm_addr_d;
        end
    end

    assign o_dm_addr        = dm_addr_q;
    assign o_dm_enable      = dm_en_q;
    assign o_dm_enable_addr = dm_en_q;
    assign o_dm_enable_read = dm_en_q;
    assign o_enable_mem     = dm_en_q;
`else
    assign o_dm_addr        = '0;
    assign o_dm_enable      = 1'b0;
    assign o_dm_enable_addr = 1'b0;
    assign o_dm_enable_read = 1'b0;
    assign o_enable_mem     = 1'b0;
`endif

    assign ser_done = (state_q == StDumpWait) && i_tx_done;

    debug_word_serializer #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS)
    ) u_serializer (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (state_q == StDumpCapture),
        .i_word      (ser_word),
        .i_start     (state_q == StDumpSend),
        .i_tx_done   (ser_done),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_word_done (word_done)
    );

    assign o_im_data         = word_q;
    assign o_im_addr         = im_addr_q;
    assign o_im_enable_write = im_we_q;
    assign o_debug_unit      = debug_q;
    assign o_en_read         = en_read_q;
    assign o_enable_pipe     = pipe_q;
    assign o_br_addr         = br_addr_q;
    assign o_br_enable       = br_en_q;
    assign o_busy            = busy_q;

endmodule
